p_hit_sched: RTL and testbench

- Per-ray scheduler for the plane-hit datapath (p_hit_1).
- Accepts one ray (origin, dir) and walks triangles 0..num_tris-1 from a synchronous triangle memory.
- Issues each triangle's normal/v0 together with the latched ray into p_hit_1. Retires the t results in order and reports the nearest valid hit (t, triangle index) to the downstream shading/intersection stage.

---
 rtl/p_hit_sched.sv | 207 ++++++++++++++++++++
 tb/tb_p_hit_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/p_hit_sched.sv
// Per-ray triangle scheduler for p_hit_1: streams triangles in, retires t results in order, keeps the nearest hit.
// Optional macro P_HIT_SCHED_TMAX_EN adds a per-ray t_max input as upper bound and initial t_min.
module p_hit_sched #(
    parameter int unsigned        D_BITS          = 32,
    parameter int unsigned        Q_BITS          = 16,
    parameter int unsigned        IDX_BITS        = 10,
    parameter int unsigned        MAX_OUTSTANDING = 8,
    parameter logic [D_BITS-1:0]  T_EPS           = D_BITS'(64)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         ray_valid,
    output logic                         ray_ready,
    input  logic [2:0][D_BITS-1:0]       origin,
    input  logic [2:0][D_BITS-1:0]       dir,
    input  logic [IDX_BITS:0]            num_tris,
`ifdef P_HIT_SCHED_TMAX_EN
    input  logic [D_BITS-1:0]            t_max,
`endif
    output logic [IDX_BITS-1:0]          tri_addr,
    output logic                         tri_rd_en,
    input  logic [2:0][D_BITS-1:0]       tri_normal,
    input  logic [2:0][D_BITS-1:0]       tri_v0,
    output logic [2:0][D_BITS-1:0]       ph_tri_normal,
    output logic [2:0][D_BITS-1:0]       ph_v0,
    output logic [2:0][D_BITS-1:0]       ph_origin,
    output logic [2:0][D_BITS-1:0]       ph_dir,
    output logic                         ph_wr_en,
    input  logic [1:0]                   ph_in_full,
    input  logic [D_BITS-1:0]            ph_out,
    input  logic                         ph_out_empty,
    output logic                         ph_out_rd_en,
    output logic                         result_valid,
    input  logic                         result_ack,
    output logic                         hit,
    output logic [D_BITS-1:0]            t_min,
    output logic [IDX_BITS-1:0]          tri_idx_min
);

    localparam int unsigned        CNT_W     = IDX_BITS + 1;
    localparam logic [D_BITS-1:0]  T_MAX_POS = {1'b0, {(D_BITS-1){1'b1}}};

    // Outstanding count must fit in p_hit_1's output FIFO; t needs an integer part.
    if (MAX_OUTSTANDING > 16 || Q_BITS >= D_BITS) begin : g_cfg_err
        $error("p_hit_sched: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          r_iss_idx;
    logic [CNT_W-1:0]          r_ret_idx;
    logic [CNT_W-1:0]          r_num_tris;
    logic [2:0][D_BITS-1:0]    r_origin;
    logic [2:0][D_BITS-1:0]    r_dir;
    logic                      r_hit;
    logic [D_BITS-1:0]         r_t_min;
    logic [IDX_BITS-1:0]       r_idx_min;
    logic [D_BITS-1:0]         w_t_hi;

    logic [CNT_W-1:0]          w_outst;
    logic [CNT_W-1:0]          w_iss_inc;
    logic                      w_accept;
    logic                      w_retire_en;
    logic                      w_pop;
    logic                      w_take;
    logic                      w_ray_ready;
    logic                      w_tri_rd_en;
    logic                      w_ph_wr_en;
    logic                      w_result_valid;

`ifdef P_HIT_SCHED_TMAX_EN
    logic [D_BITS-1:0]         r_t_max;
    assign w_t_hi = r_t_max;
`else
    assign w_t_hi = T_MAX_POS;
`endif

    assign w_outst   = r_iss_idx - r_ret_idx;
    assign w_iss_inc = r_iss_idx + CNT_W'(1);
    assign w_accept  = (r_state == S_IDLE) && ray_valid;

    // In-order retire; a result is only popped while a ray owns entries in p_hit_1.
    assign w_pop  = w_retire_en && !ph_out_empty && (r_ret_idx < r_num_tris);
    assign w_take = w_pop
                 && ($signed(ph_out) >= $signed(T_EPS))
                 && ($signed(ph_out) <  $signed(r_t_min))
                 && ($signed(ph_out) <  $signed(w_t_hi));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ray_ready    = 1'b0;
        w_tri_rd_en    = 1'b0;
        w_ph_wr_en     = 1'b0;
        w_result_valid = 1'b0;
        w_retire_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ray_ready = 1'b1;
                if (ray_valid) begin
                    w_state_nxt = (num_tris != '0) ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                w_retire_en = 1'b1;
                if (w_outst < CNT_W'(MAX_OUTSTANDING)) begin
                    w_tri_rd_en = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Memory data is held until the next read, so stalling here is safe.
                w_retire_en = 1'b1;
                if (ph_in_full == 2'b00) begin
                    w_ph_wr_en  = 1'b1;
                    w_state_nxt = (w_iss_inc < r_num_tris) ? S_READ : S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_retire_en = 1'b1;
                if (r_ret_idx == r_num_tris) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_result_valid = 1'b1;
                if (result_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Ray latch, issue/retire counters and nearest-hit tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_iss_idx  <= '0;
            r_ret_idx  <= '0;
            r_num_tris <= '0;
            r_origin   <= '0;
            r_dir      <= '0;
            r_hit      <= 1'b0;
            r_t_min    <= T_MAX_POS;
            r_idx_min  <= '0;
`ifdef P_HIT_SCHED_TMAX_EN
            r_t_max    <= T_MAX_POS;
`endif
        end else if (w_accept) begin
            r_iss_idx  <= '0;
            r_ret_idx  <= '0;
            r_num_tris <= num_tris;
            r_origin   <= origin;
            r_dir      <= dir;
            r_hit      <= 1'b0;
            r_idx_min  <= '0;
`ifdef P_HIT_SCHED_TMAX_EN
            r_t_max    <= t_max;
            r_t_min    <= t_max;
`else
            r_t_min    <= T_MAX_POS;
`endif
        end else begin
            if (w_ph_wr_en) begin
                r_iss_idx <= w_iss_inc;
            end
            if (w_pop) begin
                r_ret_idx <= r_ret_idx + CNT_W'(1);
            end
            if (w_take) begin
                r_t_min   <= ph_out;
                r_idx_min <= r_ret_idx[IDX_BITS-1:0];
                r_hit     <= 1'b1;
            end
        end
    end

    assign ray_ready     = w_ray_ready;
    assign tri_rd_en     = w_tri_rd_en;
    assign tri_addr      = r_iss_idx[IDX_BITS-1:0];
    assign ph_wr_en      = w_ph_wr_en;
    assign ph_out_rd_en  = w_pop;
    assign ph_tri_normal = tri_normal;
    assign ph_v0         = tri_v0;
    assign ph_origin     = r_origin;
    assign ph_dir        = r_dir;
    assign result_valid  = w_result_valid;
    assign hit           = r_hit;
    assign t_min         = r_t_min;
    assign tri_idx_min   = r_idx_min;

endmodule

// File: tb/tb_p_hit_sched.sv
// Bench for p_hit_sched: triangle memory and p_hit_1 FIFO models, directed vector table plus stall/reset sequences.
module tb_p_hit_sched;

    logic               clock = 1'b0;
    always #5 clock = ~clock;

    logic               reset;
    logic               ray_valid;
    logic               ray_ready;
    logic [2:0][31:0]   origin;
    logic [2:0][31:0]   dir;
    logic [10:0]        num_tris;
`ifdef P_HIT_SCHED_TMAX_EN
    logic [31:0]        t_max;
`endif
    logic [9:0]         tri_addr;
    logic               tri_rd_en;
    logic [2:0][31:0]   tri_normal;
    logic [2:0][31:0]   tri_v0;
    logic [2:0][31:0]   ph_tri_normal;
    logic [2:0][31:0]   ph_v0;
    logic [2:0][31:0]   ph_origin;
    logic [2:0][31:0]   ph_dir;
    logic               ph_wr_en;
    logic [1:0]         ph_in_full;
    logic [31:0]        ph_out;
    logic               ph_out_empty;
    logic               ph_out_rd_en;
    logic               result_valid;
    logic               result_ack;
    logic               hit;
    logic [31:0]        t_min;
    logic [9:0]         tri_idx_min;

    p_hit_sched dut (
        .clock(clock), .reset(reset), .ray_valid(ray_valid), .ray_ready(ray_ready),
        .origin(origin), .dir(dir), .num_tris(num_tris),
`ifdef P_HIT_SCHED_TMAX_EN
        .t_max(t_max),
`endif
        .tri_addr(tri_addr), .tri_rd_en(tri_rd_en), .tri_normal(tri_normal), .tri_v0(tri_v0),
        .ph_tri_normal(ph_tri_normal), .ph_v0(ph_v0), .ph_origin(ph_origin), .ph_dir(ph_dir),
        .ph_wr_en(ph_wr_en), .ph_in_full(ph_in_full), .ph_out(ph_out),
        .ph_out_empty(ph_out_empty), .ph_out_rd_en(ph_out_rd_en),
        .result_valid(result_valid), .result_ack(result_ack),
        .hit(hit), .t_min(t_min), .tri_idx_min(tri_idx_min)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Triangle memory (v0.x carries the index) and p_hit_1 model (t looked up by that index).
    logic [31:0]  t_tab [0:31];
    logic [31:0]  q [$];
    logic [31:0]  head_r = 32'h0;
    int           cnt_r = 0;
    int           wr_cnt = 0, rd_cnt = 0, pop_err = 0, wr_err = 0;
    logic         hold_empty, force_nonempty;

    assign ph_out       = head_r;
    assign ph_out_empty = force_nonempty ? 1'b0 : (hold_empty || cnt_r == 0);

    always @(posedge clock) begin
        if (reset) begin
            q.delete();
        end else begin
            if (tri_rd_en) rd_cnt++;
            if (ph_out_rd_en) begin
                if (q.size() == 0 || hold_empty) pop_err++;
                else void'(q.pop_front());
            end
            if (ph_wr_en) begin
                wr_cnt++;
                if (ph_in_full != 2'b00) wr_err++;
                q.push_back(t_tab[ph_v0[0][4:0]]);
            end
        end
        head_r <= (q.size() != 0) ? q[0] : 32'h0;
        cnt_r  <= q.size();
        if (tri_rd_en) begin
            tri_v0     <= {32'h0, 32'h0, 32'(tri_addr)};
            tri_normal <= {3{32'h0001_0000 + 32'(tri_addr)}};
        end
    end

    task automatic start_ray(input int n);
        ray_valid = 1'b1;
        num_tris  = 11'(n);
        origin    = {32'h3, 32'h2, 32'h1};
        dir       = {32'hA, 32'hB, 32'h0001_0000 + 32'(n)};
        @(posedge clock); #1;
        ray_valid = 1'b0;
        origin    = '0;
        dir       = '0;
    endtask

    task automatic wait_result(input int budget, output int lat, output logic to);
        lat = 1;
        to  = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (result_valid) begin
                to = 1'b0;
                break;
            end
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic ack_result(input string tag);
        result_ack = 1'b1;
        @(posedge clock); #1;
        result_ack = 1'b0;
        check({tag, "_rv_after_ack"}, 32'(result_valid), 32'd0);
        check({tag, "_ready_after_ack"}, 32'(ray_ready), 32'd1);
    endtask

    typedef struct {
        int          n;
        logic [31:0] t0, t1, t2, t3;
        logic        exp_hit;
        logic [31:0] exp_t;
        logic [31:0] exp_idx;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int   lat, wr0, rd0, bad;
        logic to;

        vecs[0] = '{1, 32'h0002_0000, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0002_0000, 32'd0};
        vecs[1] = '{4, 32'h0005_0000, 32'h0001_0000, 32'h0001_0000, 32'h0003_0000, 1'b1, 32'h0001_0000, 32'd1};
        vecs[2] = '{2, 32'hFFFF_0000, 32'h0000_0020, 32'h0, 32'h0, 1'b0, 32'h7FFF_FFFF, 32'd0};
        vecs[3] = '{0, 32'h0001_0000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h7FFF_FFFF, 32'd0};
        vecs[4] = '{3, 32'h0000_0040, 32'h0000_003F, 32'h0000_0041, 32'h0, 1'b1, 32'h0000_0040, 32'd0};
        vecs[5] = '{2, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 32'h7FFF_FFFF, 32'd0};
        vecs[6] = '{4, 32'h0003_0000, 32'h0002_8000, 32'h0002_8000, 32'h0002_0000, 1'b1, 32'h0002_0000, 32'd3};

        reset = 1'b1; ray_valid = 1'b0; result_ack = 1'b0; num_tris = '0;
        origin = '0; dir = '0; ph_in_full = 2'b00; hold_empty = 1'b0; force_nonempty = 1'b0;
        tri_v0 = '0; tri_normal = '0;
`ifdef P_HIT_SCHED_TMAX_EN
        t_max = 32'h7FFF_FFFF;
`endif
        for (int i = 0; i < 32; i++) t_tab[i] = 32'h0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_ray_ready", 32'(ray_ready), 32'd1);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_t_min", t_min, 32'h7FFF_FFFF);
        check("rst_idx_min", 32'(tri_idx_min), 32'd0);
        check("rst_rd_wr_pop", {29'd0, tri_rd_en, ph_wr_en, ph_out_rd_en}, 32'd0);
        reset = 1'b0;

        // A non-empty FIFO seen in IDLE must not be popped.
        force_nonempty = 1'b1;
        bad = 0;
        repeat (3) begin
            @(posedge clock); #1;
            if (ph_out_rd_en) bad++;
        end
        force_nonempty = 1'b0;
        check("idle_no_pop", 32'(bad), 32'd0);

        for (int i = 0; i < 7; i++) begin
            t_tab[0] = vecs[i].t0; t_tab[1] = vecs[i].t1;
            t_tab[2] = vecs[i].t2; t_tab[3] = vecs[i].t3;
            wr0 = wr_cnt; rd0 = rd_cnt;
            start_ray(vecs[i].n);
            wait_result(400, lat, to);
            check($sformatf("v%0d_timeout", i), 32'(to), 32'd0);
            check($sformatf("v%0d_hit", i), 32'(hit), 32'(vecs[i].exp_hit));
            check($sformatf("v%0d_t_min", i), t_min, vecs[i].exp_t);
            check($sformatf("v%0d_idx", i), 32'(tri_idx_min), vecs[i].exp_idx);
            check($sformatf("v%0d_wr_cnt", i), 32'(wr_cnt - wr0), 32'(vecs[i].n));
            check($sformatf("v%0d_rd_cnt", i), 32'(rd_cnt - rd0), 32'(vecs[i].n));
            check($sformatf("v%0d_dir_latch", i), ph_dir[0], 32'h0001_0000 + 32'(vecs[i].n));
            if (vecs[i].n == 0) begin
                check("v_empty_latency", 32'(lat), 32'd1);
            end else begin
                check($sformatf("v%0d_normal", i), ph_tri_normal[2], 32'h0001_0000 + 32'(vecs[i].n - 1));
            end
            if (i == 0) begin
                force_nonempty = 1'b1;
                @(posedge clock); #1;
                check("done_no_pop", 32'(ph_out_rd_en), 32'd0);
                check("done_holds", 32'(result_valid), 32'd1);
                force_nonempty = 1'b0;
            end
            ack_result($sformatf("v%0d", i));
        end

        // Input-full stall, then the outstanding limit with results held back.
        for (int i = 0; i < 20; i++) t_tab[i] = 32'h0010_0000 + 32'(i);
        t_tab[13] = 32'h0000_8000;
        t_tab[17] = 32'h0000_8000;
        hold_empty = 1'b1;
        ph_in_full = 2'b01;
        wr0 = wr_cnt; rd0 = rd_cnt;
        start_ray(20);
        bad = 0;
        repeat (6) begin
            @(posedge clock); #1;
            if (ph_wr_en) bad++;
        end
        check("stall_wr_low", 32'(bad), 32'd0);
        check("stall_wr_cnt", 32'(wr_cnt - wr0), 32'd0);
        ph_in_full = 2'b00;
        repeat (60) @(posedge clock);
        #1;
        check("limit_wr_cnt", 32'(wr_cnt - wr0), 32'd8);
        check("limit_outst", 32'(cnt_r), 32'd8);
        check("limit_no_rd", 32'(tri_rd_en), 32'd0);
        check("limit_not_done", 32'(result_valid), 32'd0);
        hold_empty = 1'b0;
        wait_result(500, lat, to);
        check("limit_timeout", 32'(to), 32'd0);
        check("limit_hit", 32'(hit), 32'd1);
        check("limit_t_min", t_min, 32'h0000_8000);
        check("limit_idx", 32'(tri_idx_min), 32'd13);
        check("limit_wr_total", 32'(wr_cnt - wr0), 32'd20);
        check("limit_rd_total", 32'(rd_cnt - rd0), 32'd20);
        ack_result("limit");

        // Reset while draining three outstanding results.
        for (int i = 0; i < 3; i++) t_tab[i] = 32'h0001_0000;
        hold_empty = 1'b1;
        start_ray(3);
        repeat (15) @(posedge clock);
        #1;
        check("drain_busy", 32'(ray_ready), 32'd0);
        check("drain_outst", 32'(cnt_r), 32'd3);
        reset = 1'b1;
        @(posedge clock); #1;
        check("midrst_ready", 32'(ray_ready), 32'd1);
        check("midrst_rv", 32'(result_valid), 32'd0);
        check("midrst_hit", 32'(hit), 32'd0);
        reset = 1'b0;
        hold_empty = 1'b0;
        @(posedge clock); #1;
        check("midrst_flushed", 32'(cnt_r), 32'd0);
        t_tab[0] = 32'h0003_0000;
`ifdef P_HIT_SCHED_TMAX_EN
        t_max = 32'h0002_0000;
`endif
        start_ray(1);
        wait_result(100, lat, to);
        check("post_rst_timeout", 32'(to), 32'd0);
`ifdef P_HIT_SCHED_TMAX_EN
        check("post_rst_hit", 32'(hit), 32'd0);
        check("post_rst_t_min", t_min, 32'h0002_0000);
`else
        check("post_rst_hit", 32'(hit), 32'd1);
        check("post_rst_t_min", t_min, 32'h0003_0000);
`endif
        check("post_rst_idx", 32'(tri_idx_min), 32'd0);
        ack_result("post_rst");

        check("model_pop_err", 32'(pop_err), 32'd0);
        check("model_wr_err", 32'(wr_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
